// File: rtl/cyclic_lamp.sv
`default_nettype none
// ============================================================================
//  Module   : cyclic_lamp
//  Purpose  : One-hot R/G/Y lamp sequencer with programmable per-phase dwell.
//  Revision : 1.0 - initial release
// ============================================================================
module cyclic_lamp #(
    parameter int RED_CYCLES    = 1,
    parameter int GREEN_CYCLES  = 1,
    parameter int YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [0:2] light
);

    // Dwell limits are stored as cycles-1; a parameter of 0 behaves like 1.
    localparam logic [15:0] c_red_lim    = (RED_CYCLES    <= 1) ? 16'd0 : 16'(RED_CYCLES    - 1);
    localparam logic [15:0] c_green_lim  = (GREEN_CYCLES  <= 1) ? 16'd0 : 16'(GREEN_CYCLES  - 1);
    localparam logic [15:0] c_yellow_lim = (YELLOW_CYCLES <= 1) ? 16'd0 : 16'(YELLOW_CYCLES - 1);

    localparam logic [1:0] c_st_red    = 2'd0;
    localparam logic [1:0] c_st_green  = 2'd1;
    localparam logic [1:0] c_st_yellow = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [0:2]  r_light;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_lim;
    logic        w_done;
    logic [0:2]  w_light_nxt;

    always_comb begin
        w_lim       = 16'd0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;

        case (r_state)
            c_st_red:    w_lim = c_red_lim;
            c_st_green:  w_lim = c_green_lim;
            c_st_yellow: w_lim = c_yellow_lim;
            default:     w_lim = 16'd0;
        endcase

        w_done = (r_cnt == w_lim);

        case (r_state)
            c_st_red: begin
                if (w_done) begin
                    w_state_nxt = c_st_green;
                    w_cnt_nxt   = 16'd0;
                end
            end
            c_st_green: begin
                if (w_done) begin
                    w_state_nxt = c_st_yellow;
                    w_cnt_nxt   = 16'd0;
                end
            end
            c_st_yellow: begin
                if (w_done) begin
                    w_state_nxt = c_st_red;
                    w_cnt_nxt   = 16'd0;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean Red phase.
                w_state_nxt = c_st_red;
                w_cnt_nxt   = 16'd0;
            end
        endcase

        case (w_state_nxt)
            c_st_green:  w_light_nxt = 3'b010;
            c_st_yellow: w_light_nxt = 3'b001;
            default:     w_light_nxt = 3'b100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_red;
            r_cnt   <= 16'd0;
            r_light <= 3'b100;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_light <= w_light_nxt;
        end
    end

    assign light = r_light;

endmodule
`default_nettype wire

// File: tb/tb_cyclic_lamp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cyclic_lamp
//  Purpose  : Self-checking bench for cyclic_lamp across three parameter sets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cyclic_lamp;

    logic       clk;
    logic       rst;
    logic [0:2] light_a;   // defaults 1/1/1
    logic [0:2] light_b;   // 3/2/1
    logic [0:2] light_c;   // 2/0/4

    int checks;
    int errors;
    int t_since_rst;
    bit started;

    cyclic_lamp u_dut_a (.clk(clk), .rst(rst), .light(light_a));

    cyclic_lamp #(.RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1))
        u_dut_b (.clk(clk), .rst(rst), .light(light_b));

    cyclic_lamp #(.RED_CYCLES(2), .GREEN_CYCLES(0), .YELLOW_CYCLES(4))
        u_dut_c (.clk(clk), .rst(rst), .light(light_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    // Lamp expected t edges after the most recent reset edge (t=0 is the reset edge).
    function automatic logic [0:2] model(input int t, input int r, input int g, input int y);
        int rr, gg, yy, m;
        rr = eff(r);
        gg = eff(g);
        yy = eff(y);
        m  = t % (rr + gg + yy);
        if (m < rr)           return 3'b100;
        else if (m < rr + gg) return 3'b010;
        else                  return 3'b001;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_since_rst <= 0;
            started     <= 1'b1;
        end else begin
            t_since_rst <= t_since_rst + 1;
        end
    end

    task automatic cmp(input string name, input logic [0:2] act, input logic [0:2] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, t_since_rst, act, exp);
        end
    endtask

    task automatic onehot(input string name, input logic [0:2] act);
        checks++;
        if (!(act === 3'b100 || act === 3'b010 || act === 3'b001)) begin
            errors++;
            $display("FAIL %s onehot actual=%b required=one of 100/010/001", name, act);
        end
    endtask

    // Model comparison on every cycle once a reset edge has been seen.
    always @(negedge clk) begin
        if (started) begin
            cmp("model_a", light_a, model(t_since_rst, 1, 1, 1));
            cmp("model_b", light_b, model(t_since_rst, 3, 2, 1));
            cmp("model_c", light_c, model(t_since_rst, 2, 0, 4));
            onehot("a", light_a);
            onehot("b", light_b);
            onehot("c", light_c);
        end
    end

    // Advance one edge and pin DUT b against a hand-computed literal.
    task automatic step_b(input string name, input logic [0:2] exp);
        @(negedge clk);
        cmp(name, light_b, exp);
    endtask

    initial begin
        logic [0:2] seq_b [7];
        logic [0:2] seq_a [4];
        logic [0:2] seq_c [7];
        checks      = 0;
        errors      = 0;
        started     = 1'b0;
        t_since_rst = 0;
        rst         = 1'b0;
        seq_b = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
        seq_a = '{3'b100, 3'b010, 3'b001, 3'b100};
        seq_c = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};

        @(negedge clk);
        @(negedge clk);

        // Single reset edge, then literal sequences for all three parameter sets.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("lit_rst_a", light_a, seq_a[0]);
        cmp("lit_rst_b", light_b, seq_b[0]);
        cmp("lit_rst_c", light_c, seq_c[0]);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) cmp("lit_seq_a", light_a, seq_a[i]);
            cmp("lit_seq_b", light_b, seq_b[i]);
            cmp("lit_seq_c", light_c, seq_c[i]);
        end
        // Four full periods of the 3/2/1 set.
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i < 7; i++) step_b("lit_period_b", seq_b[i]);
        end

        // Reset on the first Green cycle.
        while (light_b !== 3'b010 || t_since_rst % 6 != 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("lit_mid_green_b", light_b, 3'b100);
        step_b("lit_mid_green_red1", 3'b100);
        step_b("lit_mid_green_red2", 3'b100);
        step_b("lit_mid_green_grn", 3'b010);

        // Reset held for five edges.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("lit_hold_a", light_a, 3'b100);
            cmp("lit_hold_b", light_b, 3'b100);
        end
        rst = 1'b0;
        step_b("lit_release_red", 3'b100);
        step_b("lit_release_red", 3'b100);
        step_b("lit_release_grn", 3'b010);

        // Reset on the edge that would end Yellow.
        while (light_b !== 3'b001) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("lit_ybound_b", light_b, 3'b100);
        step_b("lit_ybound_red", 3'b100);
        step_b("lit_ybound_red", 3'b100);
        step_b("lit_ybound_grn", 3'b010);

        // Random reset pulses and holds, checked by the model process.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 2) != 0) rst = 1'b1;
            else rst = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
